// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and default geometry for the systolic array controller
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      DONE
   } state_t;

   localparam int N_DEF      = 4;
   localparam int KW_DEF     = 16;
   localparam int PE_LAT_DEF = 1;

endpackage

// File: rtl/systolic_en_gen.sv
// rtl/systolic_en_gen.sv - row/column operand-inject enables for the skewed feed wavefront
module systolic_en_gen
   import systolic_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int KW = KW_DEF
) (
   input  logic [KW:0]   feed_t,
   input  logic [KW-1:0] k_reg,
   input  logic          in_feed,
   output logic [N-1:0]  a_en,
   output logic [N-1:0]  b_en
);

   // Lane i is live while i <= t <= i+k-1, evaluated as 0 <= t-i < k in KW+1 bits so nothing wraps
   always_comb begin
      a_en = '0;
      for (int i = 0; i < N; i++) begin
         if (in_feed && (feed_t >= (KW+1)'(i)) && ((feed_t - (KW+1)'(i)) < {1'b0, k_reg})) begin
            a_en[i] = 1'b1;
         end
      end
      b_en = a_en;
   end

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - sequencer for one clear/feed/drain pass of an N x N systolic array
module systolic_ctrl
   import systolic_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int KW     = KW_DEF,
   parameter int PE_LAT = PE_LAT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [KW-1:0] cfg_k,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          pe_clr,
   output logic [KW-1:0] feed_t,
   output logic [N-1:0]  a_en,
   output logic [N-1:0]  b_en
);

   localparam logic [KW:0] N_M2       = (KW+1)'(N - 2);
   localparam logic [KW:0] DRAIN_LAST = (KW+1)'(N + PE_LAT - 2);

   state_t        state_q, state_d;
   logic [KW:0]   cnt_q, cnt_d;
   logic [KW-1:0] k_reg, k_d;
   logic [KW:0]   feed_last;
   logic          in_feed_d;
   logic [N-1:0]  a_en_d, b_en_d;

   assign feed_last = {1'b0, k_reg} + N_M2;

   // Next state, phase counter and latched K; outputs are derived from the next state so they register cleanly
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_reg;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start) begin
               state_d = CLEAR;
               k_d     = cfg_k;
            end
         end
         CLEAR: begin
            cnt_d   = '0;
            state_d = (k_reg == '0) ? DONE : FEED;
         end
         FEED: begin
            if (cnt_q == feed_last) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      if (abort && (state_q == CLEAR || state_q == FEED || state_q == DRAIN)) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   assign in_feed_d = (state_d == FEED);

   systolic_en_gen #(
      .N  (N),
      .KW (KW)
   ) u_en_gen (
      .feed_t  (cnt_d),
      .k_reg   (k_reg),
      .in_feed (in_feed_d),
      .a_en    (a_en_d),
      .b_en    (b_en_d)
   );

   // State, counter and every output are flops so nothing combinational reaches the ports
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         k_reg   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pe_clr  <= 1'b0;
         feed_t  <= '0;
         a_en    <= '0;
         b_en    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_reg   <= k_d;
         busy    <= (state_d == CLEAR) || (state_d == FEED) || (state_d == DRAIN);
         done    <= (state_d == DONE);
         pe_clr  <= (state_d == CLEAR);
         feed_t  <= in_feed_d ? cnt_d[KW-1:0] : '0;
         a_en    <= a_en_d;
         b_en    <= b_en_d;
      end
   end

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - self-checking bench for systolic_ctrl against a pass-timeline model
module tb_systolic_ctrl;

   localparam int N      = 4;
   localparam int KW     = 16;
   localparam int PE_LAT = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [KW-1:0] cfg_k;
   logic          abort;
   logic          busy;
   logic          done;
   logic          pe_clr;
   logic [KW-1:0] feed_t;
   logic [N-1:0]  a_en;
   logic [N-1:0]  b_en;

   int checks = 0;
   int errors = 0;

   systolic_ctrl #(.N(N), .KW(KW), .PE_LAT(PE_LAT)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .cfg_k  (cfg_k),
      .abort  (abort),
      .busy   (busy),
      .done   (done),
      .pe_clr (pe_clr),
      .feed_t (feed_t),
      .a_en   (a_en),
      .b_en   (b_en)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a pass is a timeline of cycles c=1.. after the accepted start edge
   // c=1 clear; K=0: c=2 done; else c=2..K+N feed (t=c-2), then N-1+PE_LAT drain cycles, then done
   logic m_act;
   int   m_k;
   int   m_c;

   function automatic int phase_of(input logic act, input int k, input int c);
      if (!act) return 0;
      if (c == 1) return 1;
      if (k == 0) return (c == 2) ? 4 : 0;
      if (c <= k + N) return 2;
      if (c <= k + 2*N - 1 + PE_LAT) return 3;
      if (c == k + 2*N + PE_LAT) return 4;
      return 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_act <= 1'b0;
         m_k   <= 0;
         m_c   <= 0;
      end else if (m_act) begin
         if (abort && phase_of(m_act, m_k, m_c) >= 1 && phase_of(m_act, m_k, m_c) <= 3)
            m_act <= 1'b0;
         else if (phase_of(m_act, m_k, m_c) == 4)
            m_act <= 1'b0;
         else
            m_c <= m_c + 1;
      end else if (start) begin
         m_act <= 1'b1;
         m_k   <= int'(cfg_k);
         m_c   <= 1;
      end
   end

   always @(negedge clk) begin
      int p;
      int t;
      logic [N-1:0] e;
      p = phase_of(m_act, m_k, m_c);
      t = (p == 2) ? m_c - 2 : 0;
      e = '0;
      if (p == 2)
         for (int i = 0; i < N; i++)
            if (t >= i && t <= i + m_k - 1) e[i] = 1'b1;
      check("busy",   32'(busy),   32'(p >= 1 && p <= 3));
      check("done",   32'(done),   32'(p == 4));
      check("pe_clr", 32'(pe_clr), 32'(p == 1));
      check("feed_t", 32'(feed_t), 32'(t));
      check("a_en",   32'(a_en),   32'(e));
      check("b_en",   32'(b_en),   32'(e));
   end

   int       done_cnt, done_cyc, feed_cnt, pe_clr_c, abort_c;
   logic [N-1:0] a_tr [0:15];
   logic [N-1:0] exp_a [0:6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

   task automatic do_start(input int k);
      @(posedge clk);
      #2 start = 1'b1;
      cfg_k = KW'(k);
      @(posedge clk);
      #2 start = 1'b0;
   endtask

   task automatic watch(input int ncyc, input int abort_t, input int inj_c);
      done_cnt = 0; done_cyc = -1; feed_cnt = 0; pe_clr_c = -1; abort_c = -1;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         abort = 1'b0;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (pe_clr && pe_clr_c < 0) pe_clr_c = c;
         if (a_en != '0 && feed_cnt < 16) begin
            a_tr[feed_cnt] = a_en;
            feed_cnt++;
         end
         if (abort_c >= 0 && c == abort_c + 1) begin
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_a_en", 32'(a_en), 32'd0);
            check("abort_b_en", 32'(b_en), 32'd0);
         end
         if (abort_t >= 0 && abort_c < 0 && busy && int'(feed_t) == abort_t) begin
            abort = 1'b1;
            abort_c = c;
         end
         if (c == inj_c) begin
            start = 1'b1;
            cfg_k = KW'(9);
         end
         if (c == inj_c + 2) start = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; cfg_k = '0; abort = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_a_en", 32'(a_en), 32'd0);
      #1 rst = 1'b0;

      // Nominal K=4
      do_start(4);
      watch(20, -1, -1);
      check("nom_pe_clr_cycle", 32'(pe_clr_c), 32'd1);
      check("nom_feed_cycles", 32'(feed_cnt), 32'd7);
      for (int i = 0; i < 7; i++) check("nom_a_en_seq", 32'(a_tr[i]), 32'(exp_a[i]));
      check("nom_done_cycle", 32'(done_cyc), 32'd13);
      check("nom_done_count", 32'(done_cnt), 32'd1);

      // Zero-K
      do_start(0);
      watch(6, -1, -1);
      check("zk_done_cycle", 32'(done_cyc), 32'd2);
      check("zk_feed_cycles", 32'(feed_cnt), 32'd0);
      check("zk_done_count", 32'(done_cnt), 32'd1);

      // Abort at feed_t=3
      do_start(4);
      watch(25, 3, -1);
      check("abort_cycle", 32'(abort_c), 32'd5);
      check("abort_done_count", 32'(done_cnt), 32'd0);

      // start re-asserted and cfg_k changed mid-pass
      do_start(4);
      watch(25, -1, 4);
      check("ign_done_count", 32'(done_cnt), 32'd1);
      check("ign_done_cycle", 32'(done_cyc), 32'd13);
      check("ign_feed_cycles", 32'(feed_cnt), 32'd7);

      // Asynchronous reset mid-DRAIN, then K=2
      do_start(4);
      watch(10, -1, -1);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_done", 32'(done), 32'd0);
      check("async_rst_pe_clr", 32'(pe_clr), 32'd0);
      check("async_rst_feed_t", 32'(feed_t), 32'd0);
      check("async_rst_en", 32'({a_en, b_en}), 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      do_start(2);
      watch(15, -1, -1);
      check("k2_done_cycle", 32'(done_cyc), 32'd11);
      check("k2_done_count", 32'(done_cnt), 32'd1);

      // Randomized traffic, checked every cycle by the model
      for (int it = 0; it < 3000; it++) begin
         @(posedge clk);
         #2;
         rst   = ($urandom_range(0, 250) == 0);
         start = ($urandom_range(0, 3) == 0);
         cfg_k = KW'($urandom_range(0, 9));
         abort = ($urandom_range(0, 40) == 0);
      end
      @(posedge clk);
      #2 rst = 1'b0; start = 1'b0; abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
